// File: rtl/cpu_run_controller_if.sv
// Board-side signal bundle of the run/step/breakpoint controller.
// master = processor/board side driving controls, slave = the controller.
interface cpu_run_controller_if #(
   parameter int CNT_W = 32
);
   logic             Tick;
   logic             BtnRun;
   logic             BtnStep;
   logic             BtnHalt;
   logic             BreakEn;
   logic [31:0]      BreakAddr;
   logic [31:0]      PC;
   logic             CpuEn;
   logic [1:0]       State;
   logic [1:0]       Cause;
   logic [CNT_W-1:0] CycleCount;

   modport master (
      output Tick, BtnRun, BtnStep, BtnHalt, BreakEn, BreakAddr, PC,
      input  CpuEn, State, Cause, CycleCount
   );

   modport slave (
      input  Tick, BtnRun, BtnStep, BtnHalt, BreakEn, BreakAddr, PC,
      output CpuEn, State, Cause, CycleCount
   );
endinterface

// File: rtl/cpu_run_controller.sv
// Run/step/breakpoint sequencer: turns divider ticks into single-cycle CpuEn
// pulses for the MIPS core, counts executed instructions, records stop cause.
module cpu_run_controller #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 32,
   parameter int MAX_CYCLES  = 0
) (
   input  logic                 Clk,
   input  logic                 Reset,
   cpu_run_controller_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STEP  = 2'b10,
      ST_BREAK = 2'b11
   } state_e;

   localparam logic [1:0]       CAUSE_NONE  = 2'b00;
   localparam logic [1:0]       CAUSE_HALT  = 2'b01;
   localparam logic [1:0]       CAUSE_BREAK = 2'b10;
   localparam logic [1:0]       CAUSE_LIMIT = 2'b11;
   localparam bit               LIMIT_EN    = (MAX_CYCLES != 0);
   localparam logic [CNT_W-1:0] LIMIT_CNT   = CNT_W'(MAX_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

   logic [SYNC_STAGES-1:0] run_sync_q, step_sync_q, halt_sync_q;
   logic                   run_prev_q, step_prev_q, halt_prev_q;
   logic                   run_p, step_p, halt_p;

   state_e           state_q, state_d;
   logic [1:0]       cause_q, cause_d;
   logic             skip_q, skip_d;
   logic             cpu_en_q;
   logic [CNT_W-1:0] cycle_count_q;

   logic tick_ok_s, brk_hit_s, limit_hit_s, grant_s;

   // Button synchronizers and rising-edge detectors
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         run_sync_q  <= '0;
         step_sync_q <= '0;
         halt_sync_q <= '0;
         run_prev_q  <= 1'b0;
         step_prev_q <= 1'b0;
         halt_prev_q <= 1'b0;
      end else begin
         run_sync_q  <= {run_sync_q[SYNC_STAGES-2:0],  bus.BtnRun};
         step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], bus.BtnStep};
         halt_sync_q <= {halt_sync_q[SYNC_STAGES-2:0], bus.BtnHalt};
         run_prev_q  <= run_sync_q[SYNC_STAGES-1];
         step_prev_q <= step_sync_q[SYNC_STAGES-1];
         halt_prev_q <= halt_sync_q[SYNC_STAGES-1];
      end
   end

   assign run_p  = run_sync_q[SYNC_STAGES-1]  & ~run_prev_q;
   assign step_p = step_sync_q[SYNC_STAGES-1] & ~step_prev_q;
   assign halt_p = halt_sync_q[SYNC_STAGES-1] & ~halt_prev_q;

   // A tick landing right after a granted one is dropped so CpuEn can never stay high
   assign tick_ok_s   = bus.Tick & ~cpu_en_q;
   assign brk_hit_s   = bus.BreakEn && (bus.PC == bus.BreakAddr) && !skip_q;
   assign limit_hit_s = LIMIT_EN && (cycle_count_q >= LIMIT_CNT);

   // State, cause, skip flag and the registered execute enable
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         cause_q  <= CAUSE_NONE;
         skip_q   <= 1'b0;
         cpu_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         skip_q   <= skip_d;
         cpu_en_q <= grant_s;
      end
   end

   // Next-state logic; halt always takes priority over step and run
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      skip_d  = skip_q;
      case (state_q)
         ST_IDLE: begin
            if (halt_p) begin
               state_d = ST_IDLE;
            end else if (step_p) begin
               state_d = ST_STEP;
            end else if (run_p) begin
               state_d = ST_RUN;
               cause_d = CAUSE_NONE;
               skip_d  = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (halt_p) begin
               state_d = ST_IDLE;
               cause_d = CAUSE_HALT;
            end else if (tick_ok_s && brk_hit_s) begin
               state_d = ST_BREAK;
               cause_d = CAUSE_BREAK;
            end else if (tick_ok_s && limit_hit_s) begin
               state_d = ST_BREAK;
               cause_d = CAUSE_LIMIT;
            end else if (grant_s) begin
               skip_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         ST_STEP: begin
            if (halt_p) begin
               state_d = ST_IDLE;
               cause_d = CAUSE_HALT;
            end else if (grant_s) begin
               state_d = ST_IDLE;
               skip_d  = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         ST_BREAK: begin
            if (halt_p) begin
               state_d = ST_IDLE;
            end else if (step_p) begin
               state_d = ST_STEP;
            end else if (run_p) begin
               // skip lets the instruction at the breakpoint execute once on resume
               state_d = ST_RUN;
               skip_d  = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Grant decision: a step ignores breakpoint and limit, a run honours both
   always_comb begin
      grant_s = 1'b0;
      case (state_q)
         ST_RUN:  grant_s = tick_ok_s && !halt_p && !brk_hit_s && !limit_hit_s;
         ST_STEP: grant_s = tick_ok_s && !halt_p;
         default: grant_s = 1'b0;
      endcase
   end

   // Saturating count of issued CpuEn pulses
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cycle_count_q <= '0;
      end else if (cpu_en_q && (cycle_count_q != CNT_MAX)) begin
         cycle_count_q <= cycle_count_q + CNT_W'(1);
      end else begin
         cycle_count_q <= cycle_count_q;
      end
   end

   assign bus.CpuEn      = cpu_en_q;
   assign bus.State      = state_q;
   assign bus.Cause      = cause_q;
   assign bus.CycleCount = cycle_count_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: each expected CpuEn pulse is queued
// with its expected count and PC; a negedge monitor pops and compares.
module tb_cpu_run_controller;
   typedef struct packed {
      logic [31:0] cnt;
      logic [31:0] pc;
   } exp_t;

   logic        Clk;
   logic        Reset;
   logic [31:0] pc_a, pc_b;
   logic        tick_a_prev, tick_b_prev, en_a_prev, en_b_prev;
   int          n_checks;
   int          n_fail;
   exp_t        qa[$];
   exp_t        qb[$];

   cpu_run_controller_if #(.CNT_W(32)) ifa ();
   cpu_run_controller_if #(.CNT_W(32)) ifb ();

   cpu_run_controller #(.SYNC_STAGES(2), .CNT_W(32), .MAX_CYCLES(0)) dut_a (
      .Clk(Clk), .Reset(Reset), .bus(ifa)
   );
   cpu_run_controller #(.SYNC_STAGES(2), .CNT_W(32), .MAX_CYCLES(8)) dut_b (
      .Clk(Clk), .Reset(Reset), .bus(ifb)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Processor PC models: advance one word per executed instruction
   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc_a <= 32'd0;
         pc_b <= 32'd0;
      end else begin
         if (ifa.CpuEn) pc_a <= pc_a + 32'd4;
         if (ifb.CpuEn) pc_b <= pc_b + 32'd4;
      end
   end
   assign ifa.PC = pc_a;
   assign ifb.PC = pc_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int idx, input logic [31:0] c, input logic [31:0] p);
      exp_t e;
      e.cnt = c;
      e.pc  = p;
      if (idx == 0) qa.push_back(e);
      else          qb.push_back(e);
   endtask

   task automatic mon_pulse(input int idx, input logic [31:0] cnt, input logic [31:0] pc,
                            input logic tprev, input logic eprev);
      exp_t e;
      logic have;
      have = 1'b0;
      e    = '0;
      if (idx == 0) begin
         if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      end else begin
         if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      end
      n_checks = n_checks + 1;
      if (!have) begin
         n_fail = n_fail + 1;
         $display("FAIL cpuen_unexpected[%0d]: CpuEn=1 at count %0d, none required at %0t", idx, cnt, $time);
      end else begin
         chk("cpuen_count", cnt, e.cnt);
         chk("cpuen_pc", pc, e.pc);
      end
      chk("cpuen_after_tick", {31'd0, tprev}, 32'd1);
      chk("cpuen_single", {31'd0, eprev}, 32'd0);
   endtask

   // Monitor: every CpuEn pulse must match the head of its queue
   always @(negedge Clk) begin
      if (Reset && ifa.CpuEn) mon_pulse(0, ifa.CycleCount, pc_a, tick_a_prev, en_a_prev);
      if (Reset && ifb.CpuEn) mon_pulse(1, ifb.CycleCount, pc_b, tick_b_prev, en_b_prev);
      tick_a_prev <= ifa.Tick;
      tick_b_prev <= ifb.Tick;
      en_a_prev   <= ifa.CpuEn;
      en_b_prev   <= ifb.CpuEn;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic tick(input int idx);
      if (idx == 0) ifa.Tick = 1'b1;
      else          ifb.Tick = 1'b1;
      cyc(1);
      ifa.Tick = 1'b0;
      ifb.Tick = 1'b0;
      cyc(3);
   endtask

   task automatic press(input int idx, input logic r, input logic s, input logic h);
      if (idx == 0) begin ifa.BtnRun = r; ifa.BtnStep = s; ifa.BtnHalt = h; end
      else          begin ifb.BtnRun = r; ifb.BtnStep = s; ifb.BtnHalt = h; end
      cyc(6);
      ifa.BtnRun = 1'b0; ifa.BtnStep = 1'b0; ifa.BtnHalt = 1'b0;
      ifb.BtnRun = 1'b0; ifb.BtnStep = 1'b0; ifb.BtnHalt = 1'b0;
      cyc(3);
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      cyc(3);
      Reset = 1'b1;
      cyc(2);
   endtask

   task automatic chk_a(input string tag, input logic [1:0] st, input logic [1:0] ca, input int cnt);
      chk({tag, "_state"}, 32'(ifa.State), 32'(st));
      chk({tag, "_cause"}, 32'(ifa.Cause), 32'(ca));
      chk({tag, "_count"}, ifa.CycleCount, 32'(cnt));
   endtask

   task automatic chk_b(input string tag, input logic [1:0] st, input logic [1:0] ca, input int cnt);
      chk({tag, "_state"}, 32'(ifb.State), 32'(st));
      chk({tag, "_cause"}, 32'(ifb.Cause), 32'(ca));
      chk({tag, "_count"}, ifb.CycleCount, 32'(cnt));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      Reset    = 1'b0;
      ifa.Tick = 1'b0; ifa.BtnRun = 1'b0; ifa.BtnStep = 1'b0; ifa.BtnHalt = 1'b0;
      ifa.BreakEn = 1'b0; ifa.BreakAddr = 32'd0;
      ifb.Tick = 1'b0; ifb.BtnRun = 1'b0; ifb.BtnStep = 1'b0; ifb.BtnHalt = 1'b0;
      ifb.BreakEn = 1'b0; ifb.BreakAddr = 32'd0;
      cyc(3);
      Reset = 1'b1;
      cyc(2);
      chk_a("reset", 2'b00, 2'b00, 0);
      chk("reset_cpuen", {31'd0, ifa.CpuEn}, 32'd0);

      // Idle: ticks are ignored
      for (int i = 0; i < 25; i++) tick(0);
      chk_a("idle", 2'b00, 2'b00, 0);

      // Free run for ten ticks, then halt
      press(0, 1'b1, 1'b0, 1'b0);
      chk("run_state", 32'(ifa.State), 32'd1);
      for (int i = 0; i < 10; i++) push(0, 32'(i), 32'(4 * i));
      for (int i = 0; i < 10; i++) tick(0);
      chk_a("run10", 2'b01, 2'b00, 10);
      press(0, 1'b0, 1'b0, 1'b1);
      chk_a("halt", 2'b00, 2'b01, 10);
      for (int i = 0; i < 3; i++) tick(0);
      chk("halt_count_hold", ifa.CycleCount, 32'd10);

      // Breakpoint at 0x10, then resume through it
      do_reset();
      ifa.BreakEn   = 1'b1;
      ifa.BreakAddr = 32'h0000_0010;
      press(0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) push(0, 32'(i), 32'(4 * i));
      for (int i = 0; i < 5; i++) tick(0);
      chk_a("brk", 2'b11, 2'b10, 4);
      chk("brk_pc", pc_a, 32'h10);
      press(0, 1'b1, 1'b0, 1'b0);
      chk("resume_state", 32'(ifa.State), 32'd1);
      push(0, 32'd4, 32'h10);
      push(0, 32'd5, 32'h14);
      tick(0);
      chk("resume_count", ifa.CycleCount, 32'd5);
      tick(0);
      chk_a("resume2", 2'b01, 2'b10, 6);
      press(0, 1'b0, 1'b0, 1'b1);
      chk_a("brk_halt", 2'b00, 2'b01, 6);
      ifa.BreakEn = 1'b0;

      // Step: halt cancels a pending step; single step; step+run together
      do_reset();
      press(0, 1'b0, 1'b1, 1'b0);
      chk_a("step_pend", 2'b10, 2'b00, 0);
      press(0, 1'b0, 1'b0, 1'b1);
      chk_a("step_halt", 2'b00, 2'b01, 0);
      tick(0);
      press(0, 1'b0, 1'b1, 1'b0);
      push(0, 32'd0, 32'd0);
      tick(0);
      chk_a("step1", 2'b00, 2'b01, 1);
      tick(0);
      press(0, 1'b1, 1'b1, 1'b0);
      chk("steprun_state", 32'(ifa.State), 32'd2);
      push(0, 32'd1, 32'd4);
      tick(0);
      tick(0);
      chk_a("steprun", 2'b00, 2'b01, 2);

      // Asynchronous reset while a CpuEn pulse is in flight
      press(0, 1'b1, 1'b0, 1'b0);
      push(0, 32'd2, 32'd8);
      tick(0);
      ifa.Tick = 1'b1;
      cyc(1);
      ifa.Tick = 1'b0;
      #2;
      Reset = 1'b0;
      #1;
      chk("rst_cpuen", {31'd0, ifa.CpuEn}, 32'd0);
      chk_a("rst_mid", 2'b00, 2'b00, 0);
      cyc(2);
      Reset = 1'b1;
      cyc(2);
      for (int i = 0; i < 3; i++) tick(0);
      chk_a("rst_after", 2'b00, 2'b00, 0);

      // Instruction limit of 8 on instance B
      do_reset();
      press(1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) push(1, 32'(i), 32'(4 * i));
      for (int i = 0; i < 9; i++) tick(1);
      chk_b("limit", 2'b11, 2'b11, 8);
      press(1, 1'b1, 1'b0, 1'b0);
      chk("limit_resume_state", 32'(ifb.State), 32'd1);
      tick(1);
      chk_b("limit_rebreak", 2'b11, 2'b11, 8);
      press(1, 1'b0, 1'b0, 1'b1);
      chk_b("limit_halt", 2'b00, 2'b11, 8);
      press(1, 1'b0, 1'b1, 1'b0);
      push(1, 32'd8, 32'd32);
      tick(1);
      chk_b("limit_step", 2'b00, 2'b11, 9);

      cyc(4);
      chk("queue_a_drained", 32'(qa.size()), 32'd0);
      chk("queue_b_drained", 32'(qb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
